ps2_keystate: RTL and testbench
===============================

# ps2_keystate

PS/2 keyboard front end: synchronises the raw PS/2 clock/data pins, deserialises 11-bit device-to-host frames, and interprets make/break/extended prefixes. It tracks the shift and caps-lock modifier state and emits one-cycle-valid make scancodes. It sits directly upstream of `scancode2ascii`, driving its `i_scancode`, `i_shift` and `i_capslock` inputs.

## Interface
- `SYNC_STAGES`, default 2: flops in each pin synchroniser, at least 2.
- `TIMEOUT`, default 50000: watchdog limit in `clk` cycles; used only with `PS2_TIMEOUT_EN`.
- `clk`  in  1  system clock; every flop is on its rising edge.
- `i_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `i_ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `o_scancode`  out  8  last accepted make code; holds until the next one.
- `o_valid`  out  1  one-cycle pulse when `o_scancode` updates.
- `o_shift`  out  1  left-shift held OR right-shift held (level).
- `o_capslock`  out  1  caps-lock toggle state (level).
- `o_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Each pin passes through a `SYNC_STAGES` synchroniser. A falling edge is a synced clock of 0 with a previous sample of 1. The FSM advances only on falling edges.
- Receive FSM:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: on the falling edge, accept the byte if stop=1 and the 9 bits (data plus parity) have odd parity. Otherwise pulse `o_err`. Return to IDLE in both cases.
- Decoder flags `brk` and `ext` act on each accepted byte:
  - 0xF0 sets `brk`. 0xE0 sets `ext`.
  - Any other byte with `ext`=1: ignored (no `o_valid`, no modifier change). Clears both flags.
  - Any other byte with `brk`=1 (release): 0x12 clears `lshift`, 0x59 clears `rshift`, 0x58 clears `caps_held`. Clears `brk`.
  - Any other byte, make: 0x12 sets `lshift`. 0x59 sets `rshift`. For 0x58, if `caps_held`=0, toggle `o_capslock` and set `caps_held`; typematic repeats do not toggle.
  - Any other make code: load `o_scancode` and pulse `o_valid`. Modifier makes never pulse `o_valid`.
- An error discards the byte and clears `brk` and `ext`. Modifier state is kept.
- `o_shift` = `lshift` | `rshift`, registered.
- Reset values: FSM IDLE; `o_scancode`=0x00; `o_valid`, `o_err`, `o_shift`, `o_capslock`=0; all flags 0; synchronisers reset to 1 (idle bus).

## Timing
- Pin falling edge to edge detect: `SYNC_STAGES`+1 cycles.
- Stop-bit edge detected at cycle N: byte accepted at N, with `o_valid`/`o_err` high during N+1 only. `o_scancode`, `o_shift` and `o_capslock` take their new values at N+1.
- Minimum gap between `o_valid` pulses is one full frame, so back-to-back pulses cannot occur.
- Asserting `i_rst_n` mid-frame aborts immediately. After release, a partial frame still on the pin is ignored until the next start bit seen in IDLE.
- A new byte is processed in the same cycle it is accepted and cannot collide with a decoder update.

## Configuration
- `PS2_TIMEOUT_EN` defined:
  - A counter clears on every falling edge and while IDLE.
  - In DATA, PARITY or STOP, reaching `TIMEOUT`-1 returns the FSM to IDLE, discards the partial byte, pulses `o_err` and clears `brk`/`ext`.
- `PS2_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely for edges; `TIMEOUT` is unused.

## Test plan
- Frame 0x1C with parity=0 and stop=1 -> one `o_valid` pulse, `o_scancode`=0x1C, `o_shift`=0, `o_err`=0.
- Bytes 12, 1C, F0 1C, F0 12 -> `o_shift`=1 from the 0x12 make until the F0 12 release, then 0. Exactly one `o_valid`, with 0x1C. No `o_valid` for 0x12.
- Bytes 58, 58, F0 58, 58, F0 58 -> `o_capslock` goes 0->1 on the first 58, stays 1 on the repeat, then goes to 0 on the second press. No `o_valid` throughout.
- Frame 0x1C with parity=1 -> `o_err` one cycle, no `o_valid`, `o_scancode` unchanged. A following good 0x16 -> `o_valid`, 0x16.
- Bytes E0 12, E0 75, E0 F0 75, E0 F0 12 -> no `o_valid`, `o_shift` stays 0. A following 1C -> `o_valid`, 0x1C.
- With `PS2_TIMEOUT_EN`, `TIMEOUT`=100: start bit plus 4 data bits, then bus idle for 100 cycles -> `o_err` one cycle. A following full 0x16 frame decodes correctly.

Source files
------------

// File: rtl/ps2_keystate_if.sv
// PS/2 pin inputs and decoded keyboard outputs of ps2_keystate.
// The slave modport is the decoder's view; the master modport drives the pins and consumes the results.
interface ps2_keystate_if;
    logic       i_ps2_clk;
    logic       i_ps2_data;
    logic [7:0] o_scancode;
    logic       o_valid;
    logic       o_shift;
    logic       o_capslock;
    logic       o_err;

    modport slave (
        input  i_ps2_clk,
        input  i_ps2_data,
        output o_scancode,
        output o_valid,
        output o_shift,
        output o_capslock,
        output o_err
    );

    modport master (
        output i_ps2_clk,
        output i_ps2_data,
        input  o_scancode,
        input  o_valid,
        input  o_shift,
        input  o_capslock,
        input  o_err
    );
endinterface

// File: rtl/ps2_keystate.sv
// PS/2 keyboard receiver plus make/break/extended decoder with shift and caps-lock tracking.
// Optional receive watchdog is enabled by defining PS2_TIMEOUT_EN.
module ps2_keystate #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic           clk,
    input  logic           i_rst_n,
    ps2_keystate_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             sr_q, sr_d;
    logic                   par_q, par_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic [7:0]             scancode_q, scancode_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   shift_q, shift_d;
    logic                   caps_q, caps_d;
    logic                   lshift_q, lshift_d;
    logic                   rshift_q, rshift_d;
    logic                   caps_held_q, caps_held_d;
    logic                   brk_q, brk_d;
    logic                   ext_q, ext_d;

    logic ps2_clk_s, ps2_data_s, ps2_fall;
    logic byte_ok, byte_err, timeout;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign ps2_fall   = clk_prev_q & ~ps2_clk_s;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    assign timeout  = (state_q != S_IDLE) && !ps2_fall && (to_cnt_q == TW'(TIMEOUT - 1));
    assign to_cnt_d = ((state_q == S_IDLE) || ps2_fall) ? '0 : to_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            par_q       <= 1'b0;
            scancode_q  <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            shift_q     <= 1'b0;
            caps_q      <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_held_q <= 1'b0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.i_ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.i_ps2_data};
            clk_prev_q  <= ps2_clk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            par_q       <= par_d;
            scancode_q  <= scancode_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            shift_q     <= shift_d;
            caps_q      <= caps_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_held_q <= caps_held_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        par_d       = par_q;
        byte_ok     = 1'b0;
        byte_err    = 1'b0;
        scancode_d  = scancode_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        caps_d      = caps_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_held_d = caps_held_q;
        brk_d       = brk_q;
        ext_d       = ext_q;

        case (state_q)
            S_IDLE: begin
                if (ps2_fall && !ps2_data_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (ps2_fall) begin
                    sr_d      = {ps2_data_s, sr_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (ps2_fall) begin
                    par_d   = ps2_data_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (ps2_fall) begin
                    // Odd parity across data plus parity bit, and stop must be high.
                    if (ps2_data_s && (^{sr_q, par_q})) byte_ok  = 1'b1;
                    else                                byte_err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d  = S_IDLE;
            byte_err = 1'b1;
        end

        if (byte_ok) begin
            if (sr_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (sr_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                brk_d = 1'b0;
                case (sr_q)
                    8'h12:   lshift_d    = 1'b0;
                    8'h59:   rshift_d    = 1'b0;
                    8'h58:   caps_held_d = 1'b0;
                    default: ;
                endcase
            end else begin
                case (sr_q)
                    8'h12: lshift_d = 1'b1;
                    8'h59: rshift_d = 1'b1;
                    8'h58: begin
                        // Typematic repeats arrive with caps_held set and must not re-toggle.
                        if (!caps_held_q) begin
                            caps_d      = ~caps_q;
                            caps_held_d = 1'b1;
                        end
                    end
                    default: begin
                        scancode_d = sr_q;
                        valid_d    = 1'b1;
                    end
                endcase
            end
        end

        if (byte_err) begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
    end

    assign shift_d = lshift_d | rshift_d;

    assign bus.o_scancode = scancode_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;
    assign bus.o_shift    = shift_q;
    assign bus.o_capslock = caps_q;

endmodule

// File: tb/tb_ps2_keystate.sv
// Directed bench for ps2_keystate: drives PS/2 frames on the pins and checks decoded state.
module tb_ps2_keystate;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   valid_cnt;
    int   err_cnt;
    int   v0;
    int   e0;

    ps2_keystate_if bus ();

    ps2_keystate #(.SYNC_STAGES(2), .TIMEOUT(100)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of the pulse outputs so pulse width is also covered.
    always @(posedge clk) begin
        if (bus.o_valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (bus.o_err   === 1'b1) err_cnt   <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic d);
        @(negedge clk);
        bus.i_ps2_data = d;
        repeat (8) @(negedge clk);
        bus.i_ps2_clk = 1'b0;
        repeat (16) @(negedge clk);
        bus.i_ps2_clk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop);
        bus.i_ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic mark;
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    task automatic report(input string name);
        $display("txn %-10s scancode=%h valid_pulses=%0d err_pulses=%0d shift=%b caps=%b",
                 name, bus.o_scancode, valid_cnt - v0, err_cnt - e0, bus.o_shift, bus.o_capslock);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        valid_cnt      = 0;
        err_cnt        = 0;
        bus.i_ps2_clk  = 1'b1;
        bus.i_ps2_data = 1'b1;
        rst_n          = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check("rst_scancode", bus.o_scancode, 8'h00);
        check("rst_valid",    bus.o_valid,    1'b0);
        check("rst_err",      bus.o_err,      1'b0);
        check("rst_shift",    bus.o_shift,    1'b0);
        check("rst_caps",     bus.o_capslock, 1'b0);
        $display("txn reset      scancode=%h shift=%b caps=%b", bus.o_scancode, bus.o_shift, bus.o_capslock);

        // Plain make code.
        mark(); send(8'h1C, 1'b0, 1'b1); report("1C");
        check("t1_valid_cnt", valid_cnt - v0, 1);
        check("t1_err_cnt",   err_cnt - e0,   0);
        check("t1_scancode",  bus.o_scancode, 8'h1C);
        check("t1_shift",     bus.o_shift,    1'b0);

        // Left shift held around a key.
        mark(); send(8'h12, 1'b0, 1'b1); report("12");
        check("t2_lshift_on",   bus.o_shift,    1'b1);
        check("t2_mod_novalid", valid_cnt - v0, 0);
        mark(); send(8'h16, 1'b0, 1'b1); report("16");
        check("t2_key_valid", valid_cnt - v0, 1);
        check("t2_key_code",  bus.o_scancode, 8'h16);
        check("t2_key_shift", bus.o_shift,    1'b1);
        mark(); send(8'hF0, 1'b0, 1'b1); send(8'h16, 1'b0, 1'b1); report("F0 16");
        check("t2_rel_novalid", valid_cnt - v0, 0);
        check("t2_rel_shift",   bus.o_shift,    1'b1);
        mark(); send(8'hF0, 1'b0, 1'b1); send(8'h12, 1'b0, 1'b1); report("F0 12");
        check("t2_shift_off", bus.o_shift, 1'b0);

        // Right shift.
        mark(); send(8'h59, 1'b0, 1'b1); report("59");
        check("t2_rshift_on", bus.o_shift, 1'b1);
        mark(); send(8'hF0, 1'b0, 1'b1); send(8'h59, 1'b0, 1'b1); report("F0 59");
        check("t2_rshift_off",   bus.o_shift,    1'b0);
        check("t2_rshift_novld", valid_cnt - v0, 0);

        // Caps lock with typematic repeat.
        mark(); send(8'h58, 1'b0, 1'b1); report("58");
        check("t3_caps_on", bus.o_capslock, 1'b1);
        send(8'h58, 1'b0, 1'b1); report("58 rpt");
        check("t3_caps_repeat", bus.o_capslock, 1'b1);
        send(8'hF0, 1'b0, 1'b1); send(8'h58, 1'b0, 1'b1); report("F0 58");
        check("t3_caps_release", bus.o_capslock, 1'b1);
        send(8'h58, 1'b0, 1'b1); report("58");
        check("t3_caps_off", bus.o_capslock, 1'b0);
        send(8'hF0, 1'b0, 1'b1); send(8'h58, 1'b0, 1'b1); report("F0 58");
        check("t3_caps_final",   bus.o_capslock, 1'b0);
        check("t3_caps_novalid", valid_cnt - v0, 0);

        // Parity error then recovery.
        mark(); send(8'h2A, 1'b1, 1'b1); report("2A badpar");
        check("t4_par_err",     err_cnt - e0,   1);
        check("t4_par_novalid", valid_cnt - v0, 0);
        check("t4_par_keep",    bus.o_scancode, 8'h16);
        mark(); send(8'h1C, 1'b0, 1'b1); report("1C");
        check("t4_recover_valid", valid_cnt - v0, 1);
        check("t4_recover_code",  bus.o_scancode, 8'h1C);

        // Stop-bit error.
        mark(); send(8'h2A, 1'b0, 1'b0); report("2A badstop");
        check("t4_stop_err",     err_cnt - e0,   1);
        check("t4_stop_novalid", valid_cnt - v0, 0);

        // An error clears a pending break prefix, so the next byte is a make.
        mark(); send(8'hF0, 1'b0, 1'b1); send(8'h33, 1'b1, 1'b1); send(8'h2A, 1'b0, 1'b1); report("F0 err 2A");
        check("t4_brk_cleared", valid_cnt - v0, 1);
        check("t4_brk_code",    bus.o_scancode, 8'h2A);

        // Extended sequences are ignored entirely.
        mark();
        send(8'hE0, 1'b0, 1'b1); send(8'h12, 1'b0, 1'b1);
        send(8'hE0, 1'b0, 1'b1); send(8'h75, 1'b0, 1'b1);
        send(8'hE0, 1'b0, 1'b1); send(8'hF0, 1'b0, 1'b1); send(8'h75, 1'b0, 1'b1);
        send(8'hE0, 1'b0, 1'b1); send(8'hF0, 1'b0, 1'b1); send(8'h12, 1'b0, 1'b1);
        report("E0 seq");
        check("t5_ext_novalid", valid_cnt - v0, 0);
        check("t5_ext_shift",   bus.o_shift,    1'b0);
        check("t5_ext_code",    bus.o_scancode, 8'h2A);
        mark(); send(8'h1C, 1'b0, 1'b1); report("1C");
        check("t5_after_valid", valid_cnt - v0, 1);
        check("t5_after_code",  bus.o_scancode, 8'h1C);

        // A clock pulse with data high in IDLE is not a start bit.
        mark(); ps2_bit(1'b1); repeat (10) @(negedge clk);
        send(8'h16, 1'b0, 1'b1); report("glitch 16");
        check("t6_glitch_valid", valid_cnt - v0, 1);
        check("t6_glitch_code",  bus.o_scancode, 8'h16);
        check("t6_glitch_err",   err_cnt - e0,   0);

`ifdef PS2_TIMEOUT_EN
        // Partial frame abandoned on the bus.
        mark();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        bus.i_ps2_data = 1'b1;
        repeat (150) @(negedge clk);
        report("timeout");
        check("t7_timeout_err",  err_cnt - e0,   1);
        check("t7_timeout_nov",  valid_cnt - v0, 0);
        mark(); send(8'h1C, 1'b0, 1'b1); report("1C");
        check("t7_after_valid", valid_cnt - v0, 1);
        check("t7_after_code",  bus.o_scancode, 8'h1C);
`endif

        // Reset mid-frame, then a clean frame.
        mark();
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check("t8_rst_async_code", bus.o_scancode, 8'h00);
        repeat (3) @(negedge clk);
        check("t8_rst_shift", bus.o_shift,    1'b0);
        check("t8_rst_caps",  bus.o_capslock, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        mark(); send(8'h29, 1'b0, 1'b1); report("rst 29");
        check("t8_post_valid", valid_cnt - v0, 1);
        check("t8_post_code",  bus.o_scancode, 8'h29);
        check("t8_post_err",   err_cnt - e0,   0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
